sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port arbiter (display reader, writer) in front of an asynchronous 16-bit SRAM.
// Latency: grant 1 cycle after request; read data 2 cycles after rd_gnt; a read occupies 2 cycles, a write 3.
// Backpressure: requesters hold req/payload until their one-cycle gnt; reads are capped at MAX_RD_BURST while a write waits.
module sram_arbiter #(
    parameter int MAX_RD_BURST = 8
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        rd_req,
    input  logic [17:0] rd_addr,
    output logic        rd_gnt,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_req,
    input  logic [17:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_be,
    output logic        wr_gnt,
    output logic        busy,
    inout  wire  [15:0] sram_DQ,
    output logic [17:0] sram_ADDR,
    output logic        sram_LB_N,
    output logic        sram_UB_N,
    output logic        sram_CE_N,
    output logic        sram_OE_N,
    output logic        sram_WE_N
);

    localparam int SW = $clog2(MAX_RD_BURST + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_RD_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_WR1,
        S_WR2,
        S_WR3
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic [17:0]   r_addr;
    logic [15:0]   r_wdata;
    logic [15:0]   r_rd_data;
    logic          r_rd_gnt;
    logic          r_wr_gnt;
    logic          r_rd_valid;
    logic          r_ce_n;
    logic          r_oe_n;
    logic          r_we_n;
    logic          r_lb_n;
    logic          r_ub_n;
    logic          r_dq_oe;

    logic          w_decide;
    logic          w_rd_win;
    logic          w_wr_win;

    // IDLE and the last cycle of each access are the only points where a new owner is chosen.
    assign w_decide = (r_state == S_IDLE) || (r_state == S_RD2) || (r_state == S_WR3);
    // Reads win unless a waiting write has already been starved for a full burst.
    assign w_rd_win = w_decide && rd_req && (!wr_req || (r_streak < MAX_S));
    assign w_wr_win = w_decide && !w_rd_win && wr_req;

    // Access sequencer: state, latched payload and every SRAM strobe are registered together.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= S_IDLE;
            r_streak   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_rd_gnt   <= 1'b0;
            r_wr_gnt   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_ub_n     <= 1'b1;
            r_dq_oe    <= 1'b0;
        end else begin
            r_rd_gnt   <= 1'b0;
            r_wr_gnt   <= 1'b0;
            // Data is captured on the edge that closes RD2, after two cycles of stable OE.
            r_rd_valid <= (r_state == S_RD2);
            if (r_state == S_RD2) begin
                r_rd_data <= sram_DQ;
            end
            if (w_decide) begin
                if (w_rd_win) begin
                    r_state  <= S_RD1;
                    r_addr   <= rd_addr;
                    r_rd_gnt <= 1'b1;
                    r_ce_n   <= 1'b0;
                    r_oe_n   <= 1'b0;
                    r_we_n   <= 1'b1;
                    r_lb_n   <= 1'b0;
                    r_ub_n   <= 1'b0;
                    r_dq_oe  <= 1'b0;
                    if (wr_req) begin
                        r_streak <= (r_streak == MAX_S) ? MAX_S : r_streak + SW'(1);
                    end else begin
                        r_streak <= '0;
                    end
                end else if (w_wr_win) begin
                    r_state  <= S_WR1;
                    r_addr   <= wr_addr;
                    r_wdata  <= wr_data;
                    r_wr_gnt <= 1'b1;
                    r_ce_n   <= 1'b0;
                    r_oe_n   <= 1'b1;
                    r_we_n   <= 1'b1;
                    r_lb_n   <= ~wr_be[0];
                    r_ub_n   <= ~wr_be[1];
                    r_dq_oe  <= 1'b1;
                    r_streak <= '0;
                end else begin
                    // Nobody asking: release the chip; the address bus keeps its last value.
                    r_state  <= S_IDLE;
                    r_ce_n   <= 1'b1;
                    r_oe_n   <= 1'b1;
                    r_we_n   <= 1'b1;
                    r_lb_n   <= 1'b1;
                    r_ub_n   <= 1'b1;
                    r_dq_oe  <= 1'b0;
                    r_streak <= '0;
                end
            end else begin
                case (r_state)
                    S_RD1: r_state <= S_RD2;
                    S_WR1: begin
                        r_state <= S_WR2;
                        r_we_n  <= 1'b0;
                    end
                    S_WR2: begin
                        // WE rises one cycle before DQ is released, giving data hold time.
                        r_state <= S_WR3;
                        r_we_n  <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sram_DQ   = r_dq_oe ? r_wdata : 16'hzzzz;
    assign sram_ADDR = r_addr;
    assign sram_CE_N = r_ce_n;
    assign sram_OE_N = r_oe_n;
    assign sram_WE_N = r_we_n;
    assign sram_LB_N = r_lb_n;
    assign sram_UB_N = r_ub_n;
    assign rd_gnt    = r_rd_gnt;
    assign wr_gnt    = r_wr_gnt;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign busy      = (r_state != S_IDLE);

endmodule
